// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Purpose  : 8N1 UART receiver. Oversamples rx, samples each bit at its
//            midpoint, rejects start-bit glitches and reports bad stop bits.
//            Feeds rx_control one byte per rx_ready pulse.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous reset, active low
//            rx           - serial line, asynchronous to clk, idle high
//            rx_data[7:0] - last correctly framed byte (LSB = first data bit)
//            rx_ready     - 1-cycle pulse, rx_data holds a new byte
//            frame_error  - 1-cycle pulse, stop bit sampled low
//            busy         - high whenever the receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       frame_error,
  output logic       busy
);

  // Clocks per oversampling tick, rounded to nearest.
  localparam int c_DIV   = (CLK_FREQ + (BAUD_RATE * OVERSAMPLE) / 2) / (BAUD_RATE * OVERSAMPLE);
  localparam int c_DIV_W = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_OS_W  = $clog2(OVERSAMPLE);

  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
  localparam logic [c_OS_W-1:0]  c_HALF_LAST = c_OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_OS_W-1:0]  c_OS_LAST   = c_OS_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [c_DIV_W-1:0]   r_div_cnt;
  logic [c_OS_W-1:0]    r_tick_cnt;
  logic [2:0]           r_bit_cnt;
  logic [7:0]           r_shreg;
  logic                 w_tick;
  logic                 w_shift;
  logic                 w_load;
  logic                 w_ferr;
  logic                 w_state_change;
  logic                 w_start_entry;

  // Two-flop synchronizer; resets to the idle (high) line level so that
  // reset release never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick         = (r_div_cnt == c_DIV_LAST);
  assign w_state_change = (w_state_next != r_state);
  assign w_start_entry  = (r_state == S_IDLE) && (w_state_next == S_START);

  // Tick divider free-runs, but is re-phased on the start edge so that tick
  // boundaries line up with the frame rather than with an arbitrary phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (w_start_entry || w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_load       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) w_state_next = S_START;
      end
      S_START: begin
        // Half a bit in: a line that is high again was only a glitch.
        if (w_tick && (r_tick_cnt == c_HALF_LAST)) begin
          w_state_next = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        // Tick count was cleared mid start bit, so a full bit of ticks
        // lands in the middle of each data bit.
        if (w_tick && (r_tick_cnt == c_OS_LAST)) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 3'd7) w_state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tick && (r_tick_cnt == c_OS_LAST)) begin
          if (r_rx_s) begin
            w_load       = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            w_ferr       = 1'b1;
            w_state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // Wait out a held-low line so a break yields a single error.
        if (r_rx_s) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shreg    <= '0;
    end else begin
      if (w_state_change) begin
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == c_OS_LAST) ? '0 : r_tick_cnt + 1'b1;
      end

      if (w_state_change) begin
        r_bit_cnt <= '0;
      end else if (w_shift) begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end

      // LSB arrives first; shifting right leaves it in bit 0 after 8 bits.
      if (w_shift) begin
        r_shreg <= {r_rx_s, r_shreg[7:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= 8'h00;
      rx_ready    <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      rx_ready    <= w_load;
      frame_error <= w_ferr;
      if (w_load) rx_data <= r_shreg;
    end
  end

  assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Purpose  : Self-checking bench for uart_rx_deserializer. Stimulus pushes
//            the expected byte/error event into a scoreboard queue; a monitor
//            pops and compares on every rx_ready / frame_error pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

  localparam int c_BIT = 160;  // clocks per bit at the bench parameters

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       frame_error;
  logic       busy;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic r_prev_evt = 1'b0;

  uart_rx_deserializer #(
    .CLK_FREQ   (1_600_000),
    .BAUD_RATE  (10_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .frame_error (frame_error),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_t e;
    e.err  = 1'b0;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // A frame error reports the unchanged previous byte on rx_data.
  task automatic expect_ferr(input logic [7:0] prior);
    exp_t e;
    e.err  = 1'b1;
    e.data = prior;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic level, input int clks);
    rx = level;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input int bit_clk, input logic stop);
    hold(1'b0, bit_clk);
    for (int i = 0; i < 8; i++) hold(d[i], bit_clk);
    hold(stop, bit_clk);
  endtask

  task automatic drain(input int max_clk);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_clk) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", exp_q.size(), 0);
  endtask

  // Monitor: compares every output pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rx_ready || frame_error) begin
      check("ready_ferr_exclusive", {31'd0, rx_ready & frame_error}, 0);
      check("pulse_not_consecutive", {31'd0, r_prev_evt}, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, rx_ready, frame_error}, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind_ferr", {31'd0, frame_error}, {31'd0, e.err});
        check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
      end
    end
    r_prev_evt = rx_ready | frame_error;
  end

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 0);
    check("reset_rx_ready", {31'd0, rx_ready}, 0);
    check("reset_frame_error", {31'd0, frame_error}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    reset = 1'b1;
    hold(1'b1, 20);

    // Single frame 0xA5
    expect_byte(8'hA5);
    send_frame(8'hA5, c_BIT, 1'b1);
    drain(4 * c_BIT);
    hold(1'b1, 2 * c_BIT);

    // Back-to-back frames, no idle gap
    expect_byte(8'h01); send_frame(8'h01, c_BIT, 1'b1);
    expect_byte(8'h00); send_frame(8'h00, c_BIT, 1'b1);
    expect_byte(8'h02); send_frame(8'h02, c_BIT, 1'b1);
    expect_byte(8'h00); send_frame(8'h00, c_BIT, 1'b1);
    expect_byte(8'h03); send_frame(8'h03, c_BIT, 1'b1);
    drain(4 * c_BIT);
    hold(1'b1, 2 * c_BIT);
    check("rx_data_hold", {24'd0, rx_data}, 32'h03);

    // Start glitch of 3 ticks: START is entered, then rejected mid start bit
    hold(1'b0, 30);
    hold(1'b1, 10);
    check("glitch_busy_in_start", {31'd0, busy}, 1);
    hold(1'b1, 3 * c_BIT);
    check("glitch_busy_cleared", {31'd0, busy}, 0);
    check("glitch_no_output", exp_q.size(), 0);

    // Bad stop bit followed by a 20-bit break
    expect_ferr(8'h03);
    send_frame(8'h3C, c_BIT, 1'b0);
    hold(1'b0, 20 * c_BIT);
    check("break_busy", {31'd0, busy}, 1);
    check("break_one_error", exp_q.size(), 0);
    hold(1'b1, c_BIT);
    check("break_exit_idle", {31'd0, busy}, 0);
    check("break_rx_data_kept", {24'd0, rx_data}, 32'h03);

    // Valid frame right after the break
    expect_byte(8'h5A);
    send_frame(8'h5A, c_BIT, 1'b1);
    drain(4 * c_BIT);
    hold(1'b1, c_BIT);

    // Reset asserted at data bit 4 of 0xFF, released one bit later
    hold(1'b0, c_BIT);
    for (int i = 0; i < 4; i++) hold(1'b1, c_BIT);
    reset = 1'b0;
    hold(1'b1, 2);
    check("midreset_rx_data", {24'd0, rx_data}, 0);
    check("midreset_rx_ready", {31'd0, rx_ready}, 0);
    check("midreset_frame_error", {31'd0, frame_error}, 0);
    check("midreset_busy", {31'd0, busy}, 0);
    hold(1'b1, c_BIT - 2);
    reset = 1'b1;
    hold(1'b1, 5 * c_BIT);
    check("midreset_frame_dropped", {24'd0, rx_data}, 0);
    expect_byte(8'h81);
    send_frame(8'h81, c_BIT, 1'b1);
    drain(4 * c_BIT);
    hold(1'b1, c_BIT);

    // Baud error of -3% then +3%
    expect_byte(8'h55);
    send_frame(8'h55, 155, 1'b1);
    expect_byte(8'hAA);
    send_frame(8'hAA, 165, 1'b1);
    drain(4 * c_BIT);
    hold(1'b1, 2 * c_BIT);
    check("final_busy", {31'd0, busy}, 0);
    check("final_rx_data", {24'd0, rx_data}, 32'hAA);
    check("final_scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
